// File: rtl/core_pipe_pkg.sv
// Shared definitions for the core_pipe execute core: ALU opcodes, flag bit
// positions and instruction field offsets.
package core_pipe_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_ADC = 4'd1,
    ALU_SUB = 4'd2,
    ALU_SBC = 4'd3,
    ALU_AND = 4'd4,
    ALU_OR  = 4'd5,
    ALU_XOR = 4'd6,
    ALU_NOT = 4'd7,
    ALU_SHL = 4'd8,
    ALU_SHR = 4'd9,
    ALU_MOV = 4'd10
  } alu_op_e;

  localparam int FLAG_C = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_O = 2;
  localparam int FLAG_Z = 3;

  localparam int F_IS_ALU   = 0;
  localparam int F_OP_LSB   = 1;
  localparam int F_MASK_LSB = 5;

  localparam int FIELD_SRCA = 0;
  localparam int FIELD_SRCB = 1;
  localparam int FIELD_DST  = 2;

  // Register index fields follow the fixed 9-bit opcode/predicate header.
  function automatic int f_field_lsb(input int field, input int idx_w);
    return 9 + field * idx_w;
  endfunction

endpackage

// File: rtl/core_pipe_alu.sv
// Combinational ALU for core_pipe: arithmetic, logic, shift and move ops
// with C/S/O/Z flag generation.
module core_pipe_alu
  import core_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic [DATA_WIDTH-1:0] i_a,
  input  logic [DATA_WIDTH-1:0] i_b,
  input  logic [3:0]            i_op,
  input  logic                  i_carry,
  output logic [DATA_WIDTH-1:0] o_result,
  output logic [3:0]            o_flags
);

  localparam int DW = DATA_WIDTH;

  logic          w_add_cin;
  logic          w_sub_bin;
  logic [DW:0]   w_sum;
  logic [DW:0]   w_diff;
  logic [DW:0]   w_ssum;
  logic [DW:0]   w_sdiff;
  logic          w_add_ovf;
  logic          w_sub_ovf;
  logic          w_c;
  logic          w_o;

  assign w_add_cin = (i_op == ALU_ADC) & i_carry;
  assign w_sub_bin = (i_op == ALU_SBC) & i_carry;

  // Zero-extended forms give carry/borrow, sign-extended forms give overflow.
  assign w_sum   = {1'b0, i_a} + {1'b0, i_b} + {{DW{1'b0}}, w_add_cin};
  assign w_diff  = {1'b0, i_a} - {1'b0, i_b} - {{DW{1'b0}}, w_sub_bin};
  assign w_ssum  = {i_a[DW-1], i_a} + {i_b[DW-1], i_b} + {{DW{1'b0}}, w_add_cin};
  assign w_sdiff = {i_a[DW-1], i_a} - {i_b[DW-1], i_b} - {{DW{1'b0}}, w_sub_bin};

  assign w_add_ovf = w_ssum[DW] ^ w_ssum[DW-1];
  assign w_sub_ovf = w_sdiff[DW] ^ w_sdiff[DW-1];

  always_comb begin
    o_result = i_a;
    w_c      = 1'b0;
    w_o      = 1'b0;
    case (i_op)
      ALU_ADD, ALU_ADC: begin
        o_result = w_sum[DW-1:0];
        w_c      = w_sum[DW];
        w_o      = w_add_ovf;
      end
      ALU_SUB, ALU_SBC: begin
        o_result = w_diff[DW-1:0];
        w_c      = w_diff[DW];
        w_o      = w_sub_ovf;
      end
      ALU_AND: o_result = i_a & i_b;
      ALU_OR:  o_result = i_a | i_b;
      ALU_XOR: o_result = i_a ^ i_b;
      ALU_NOT: o_result = ~i_a;
      ALU_SHL: begin
        o_result = {i_a[DW-2:0], 1'b0};
        w_c      = i_a[DW-1];
      end
      ALU_SHR: begin
        o_result = {1'b0, i_a[DW-1:1]};
        w_c      = i_a[0];
      end
      ALU_MOV: o_result = i_b;
      default: o_result = i_a;
    endcase
  end

  always_comb begin
    o_flags         = '0;
    o_flags[FLAG_C] = w_c;
    o_flags[FLAG_S] = o_result[DW-1];
    o_flags[FLAG_O] = w_o;
    o_flags[FLAG_Z] = (o_result == '0);
  end

endmodule

// File: rtl/core_pipe.sv
// Two-stage predicated execute core. Define CORE_PIPE_FORWARDING_EN to bypass
// the S1 commit value into operand reads; otherwise RAW hazards stall a cycle.
module core_pipe
  import core_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 4,
  parameter int NUM_FLAGS  = 4,
  parameter int REG_IDX_W  = $clog2(NUM_REGS),
  parameter int INSTR_W    = 9 + 3 * REG_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_instr_valid,
  output logic                  o_instr_ready,
  input  logic [INSTR_W-1:0]    i_instr,
  input  logic [DATA_WIDTH-1:0] i_data_in,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_data_out_valid,
  output logic [NUM_FLAGS-1:0]  o_flags_out,
  output logic                  o_busy
);

  localparam int DW       = DATA_WIDTH;
  localparam int SRCA_LSB = f_field_lsb(FIELD_SRCA, REG_IDX_W);
  localparam int SRCB_LSB = f_field_lsb(FIELD_SRCB, REG_IDX_W);
  localparam int DST_LSB  = f_field_lsb(FIELD_DST, REG_IDX_W);

  logic [REG_IDX_W-1:0] w_in_srca;
  logic [REG_IDX_W-1:0] w_in_srcb;
  logic [REG_IDX_W-1:0] w_in_dst;
  logic [DW-1:0]        w_regs [NUM_REGS];
  logic [DW-1:0]        w_op_a;
  logic [DW-1:0]        w_op_b;
  logic                 w_stall;
  logic                 w_accept;

  logic                 r_ready;
  logic                 r_s1_valid;
  logic                 r_s1_is_alu;
  logic [3:0]           r_s1_op;
  logic [3:0]           r_s1_mask;
  logic [REG_IDX_W-1:0] r_s1_dst;
  logic [DW-1:0]        r_s1_a;
  logic [DW-1:0]        r_s1_b;
  logic [DW-1:0]        r_s1_data;
  logic [NUM_FLAGS-1:0] r_flags;
  logic [DW-1:0]        r_data_out;
  logic                 r_data_out_valid;

  logic                 w_s1_store;
  logic                 w_s1_writes;
  logic                 w_pred;
  logic                 w_commit;
  logic                 w_wr_en;
  logic [DW-1:0]        w_wr_val;
  logic [DW-1:0]        w_alu_result;
  logic [3:0]           w_alu_flags;

  assign w_in_srca = i_instr[SRCA_LSB +: REG_IDX_W];
  assign w_in_srcb = i_instr[SRCB_LSB +: REG_IDX_W];
  assign w_in_dst  = i_instr[DST_LSB +: REG_IDX_W];

  assign w_s1_store  = !r_s1_is_alu && r_s1_op[0];
  assign w_s1_writes = r_s1_valid && !w_s1_store;
  assign w_pred      = ((r_s1_mask & r_flags[3:0]) == r_s1_mask);
  assign w_commit    = r_s1_valid && w_pred;
  assign w_wr_en     = w_commit && w_s1_writes;
  assign w_wr_val    = r_s1_is_alu ? w_alu_result : r_s1_data;

  core_pipe_alu #(
    .DATA_WIDTH(DW)
  ) u_alu (
    .i_a      (r_s1_a),
    .i_b      (r_s1_b),
    .i_op     (r_s1_op),
    .i_carry  (r_flags[FLAG_C]),
    .o_result (w_alu_result),
    .o_flags  (w_alu_flags)
  );

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      logic [DW-1:0] r_q;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (w_wr_en && (r_s1_dst == REG_IDX_W'(gi))) begin
          r_q <= w_wr_val;
        end
      end
      assign w_regs[gi] = r_q;
    end
  endgenerate

`ifdef CORE_PIPE_FORWARDING_EN
  assign w_op_a  = (w_wr_en && (r_s1_dst == w_in_srca)) ? w_wr_val : w_regs[w_in_srca];
  assign w_op_b  = (w_wr_en && (r_s1_dst == w_in_srcb)) ? w_wr_val : w_regs[w_in_srcb];
  assign w_stall = 1'b0;
`else
  assign w_op_a  = w_regs[w_in_srca];
  assign w_op_b  = w_regs[w_in_srcb];
  // Conservative: a predicated-false writer still stalls its reader.
  assign w_stall = i_instr_valid && w_s1_writes &&
                   ((r_s1_dst == w_in_srca) || (r_s1_dst == w_in_srcb));
`endif

  assign o_instr_ready = r_ready && !w_stall;
  assign w_accept      = i_instr_valid && o_instr_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready <= 1'b0;
    end else begin
      r_ready <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_s1_is_alu <= 1'b0;
      r_s1_op     <= '0;
      r_s1_mask   <= '0;
      r_s1_dst    <= '0;
      r_s1_a      <= '0;
      r_s1_b      <= '0;
      r_s1_data   <= '0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_is_alu <= i_instr[F_IS_ALU];
        r_s1_op     <= i_instr[F_OP_LSB +: 4];
        r_s1_mask   <= i_instr[F_MASK_LSB +: 4];
        r_s1_dst    <= w_in_dst;
        r_s1_a      <= w_op_a;
        r_s1_b      <= w_op_b;
        r_s1_data   <= i_data_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flags          <= '0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_data_out_valid <= w_commit && w_s1_store;
      if (w_commit && w_s1_store) begin
        r_data_out <= r_s1_a;
      end
      if (w_commit && r_s1_is_alu) begin
        r_flags <= w_alu_flags;
      end
    end
  end

  assign o_data_out       = r_data_out;
  assign o_data_out_valid = r_data_out_valid;
  assign o_flags_out      = r_flags;
  assign o_busy           = r_s1_valid;

endmodule

// File: tb/tb_core_pipe.sv
// Self-checking bench for core_pipe: directed scenarios plus random programs
// checked against a sequential instruction-set model.
module tb_core_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [14:0] instr = '0;
  logic [15:0] din = '0;
  logic        ready;
  logic [15:0] dout;
  logic        dv;
  logic [3:0]  flags;
  logic        busy;

  always #5 clk = ~clk;

  core_pipe #(.DATA_WIDTH(16), .NUM_REGS(4)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .i_instr_valid    (valid),
    .o_instr_ready    (ready),
    .i_instr          (instr),
    .i_data_in        (din),
    .o_data_out       (dout),
    .o_data_out_valid (dv),
    .o_flags_out      (flags),
    .o_busy           (busy)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // Architectural model, updated in program order at acceptance.
  logic [15:0] m_regs [4];
  logic [3:0]  m_flags;
  // What the DUT's execute stage holds, and what it will expose after commit.
  bit          sl_v, sl_wr, sl_st;
  logic [1:0]  sl_dst;
  logic [3:0]  sl_flags;
  logic [15:0] sl_sval;
  bit          nw_wr, nw_st;
  logic [1:0]  nw_dst;
  logic [3:0]  nw_flags;
  logic [15:0] nw_sval;
  logic [3:0]  v_flags;
  logic [15:0] e_dout;
  bit          e_dv;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] mk(input bit alu, input int op, input int mask,
                                     input int sa, input int sb, input int dst);
    logic [14:0] w;
    w        = '0;
    w[0]     = alu;
    w[4:1]   = op[3:0];
    w[8:5]   = mask[3:0];
    w[10:9]  = sa[1:0];
    w[12:11] = sb[1:0];
    w[14:13] = dst[1:0];
    return w;
  endfunction

  function automatic void m_alu(input int op, input int a, input int b, input int c,
                                output int res, output logic [3:0] f);
    int r, sr, sa, sb;
    bit cf, of;
    sa = (a >= 32768) ? a - 65536 : a;
    sb = (b >= 32768) ? b - 65536 : b;
    cf = 0; of = 0; r = a; sr = 0;
    case (op)
      0, 1: begin
        r  = a + b + ((op == 1) ? c : 0);
        sr = sa + sb + ((op == 1) ? c : 0);
        cf = (r > 65535);
        of = (sr > 32767) || (sr < -32768);
      end
      2, 3: begin
        r  = a - b - ((op == 3) ? c : 0);
        sr = sa - sb - ((op == 3) ? c : 0);
        cf = (r < 0);
        of = (sr > 32767) || (sr < -32768);
      end
      4: r = a & b;
      5: r = a | b;
      6: r = a ^ b;
      7: r = 65535 - a;
      8: begin r = a * 2; cf = (a >= 32768); end
      9: begin r = a / 2; cf = (a % 2) == 1; end
      10: r = b;
      default: r = a;
    endcase
    res = r & 65535;
    f   = {res == 0, of, res >= 32768, cf};
  endfunction

  task automatic model_exec(input logic [14:0] ins, input logic [15:0] d);
    bit alu, pred;
    int op, mask, sa, sb, dst, res;
    logic [3:0] f;
    alu  = ins[0];
    op   = int'(ins[4:1]);
    mask = int'(ins[8:5]);
    sa   = int'(ins[10:9]);
    sb   = int'(ins[12:11]);
    dst  = int'(ins[14:13]);
    pred = ((mask & int'(m_flags)) == mask);
    nw_st  = 0;
    nw_wr  = alu || (op % 2 == 0);
    nw_dst = dst[1:0];
    if (alu) begin
      m_alu(op, int'(m_regs[sa]), int'(m_regs[sb]), int'(m_flags[0]), res, f);
      if (pred) begin
        m_regs[dst] = res[15:0];
        m_flags     = f;
      end
    end else if (op % 2 == 0) begin
      if (pred) m_regs[dst] = d;
    end else begin
      nw_st   = pred;
      nw_sval = m_regs[sa];
    end
    nw_flags = m_flags;
  endtask

  task automatic tick(input bit acc);
    @(posedge clk);
    #1;
    if (sl_v) begin
      v_flags = sl_flags;
      if (sl_st) e_dout = sl_sval;
    end
    e_dv = sl_v && sl_st;
    sl_v = acc;
    if (acc) begin
      sl_wr = nw_wr; sl_st = nw_st; sl_dst = nw_dst;
      sl_flags = nw_flags; sl_sval = nw_sval;
    end
    chk("busy", busy, sl_v);
    chk("dout_valid", dv, e_dv);
    chk("dout", dout, e_dout);
    chk("flags", flags, v_flags);
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0);
  endtask

  task automatic issue(input logic [14:0] ins, input logic [15:0] d);
    int stalls, exp_stall;
    logic [1:0] sa, sb;
    sa = ins[10:9];
    sb = ins[12:11];
`ifdef CORE_PIPE_FORWARDING_EN
    exp_stall = 0;
`else
    exp_stall = (sl_v && sl_wr && (sl_dst == sa || sl_dst == sb)) ? 1 : 0;
`endif
    instr = ins; din = d; valid = 1'b1;
    #1;
    stalls = 0;
    while (ready !== 1'b1 && stalls < 3) begin
      stalls++;
      tick(0);
      #1;
    end
    chk("stall_cycles", stalls, exp_stall);
    if (ready === 1'b1) begin
      model_exec(ins, d);
      tick(1);
    end
    valid = 1'b0;
    instr = 15'($urandom);
    din   = 16'($urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) m_regs[i] = '0;
    m_flags = '0; sl_v = 0; sl_st = 0; sl_wr = 0;
    v_flags = '0; e_dout = '0; e_dv = 0;
    chk("rst_ready", ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dv", dv, 1'b0);
    chk("rst_flags", flags, 4'h0);
    chk("rst_dout", dout, 16'h0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready_hold", ready, 1'b0);
    rst_n = 1'b1;
    tick(0);
    chk("ready_after_rst", ready, 1'b1);
  endtask

  initial begin
    do_reset();

    // 0x7FFF + 1: signed overflow into the sign bit.
    issue(mk(0, 0, 0, 0, 0, 1), 16'h7FFF);
    issue(mk(0, 0, 0, 0, 0, 2), 16'h0001);
    issue(mk(1, 0, 0, 1, 2, 3), 16'h0);
    idle(2);
    chk("add_ovf_flags", flags, 4'b0110);
    issue(mk(0, 1, 0, 3, 0, 0), 16'h0);
    idle(2);
    chk("store_r3", dout, 16'h8000);
    chk("store_keeps_flags", flags, 4'b0110);

    // Predication on Z (taken) and C (skipped).
    issue(mk(1, 2, 0, 1, 1, 0), 16'h0);
    issue(mk(1, 0, 4'b1000, 0, 0, 2), 16'h0);
    issue(mk(1, 0, 4'b0001, 1, 1, 3), 16'h0);
    issue(mk(0, 1, 0, 2, 0, 0), 16'h0);
    issue(mk(0, 1, 0, 3, 0, 0), 16'h0);
    idle(2);
    chk("skip_keeps_r3", dout, 16'h8000);
    chk("z_flags", flags, 4'b1000);

    // Carry chain: 0xFFFF+0xFFFF then ADC 0+0+C.
    issue(mk(0, 0, 0, 0, 0, 0), 16'hFFFF);
    issue(mk(0, 0, 0, 0, 0, 2), 16'h0000);
    issue(mk(0, 0, 0, 0, 0, 3), 16'h0000);
    issue(mk(1, 0, 0, 0, 0, 0), 16'h0);
    issue(mk(1, 1, 0, 2, 3, 1), 16'h0);
    issue(mk(0, 1, 0, 0, 0, 0), 16'h0);
    idle(2);
    chk("add_ffff", dout, 16'hFFFE);
    issue(mk(0, 1, 0, 1, 0, 0), 16'h0);
    idle(2);
    chk("adc_result", dout, 16'h0001);

    // Predicated-false store produces no pulse.
    issue(mk(0, 1, 4'b1000, 0, 0, 0), 16'h0);
    idle(3);
    chk("pred_false_store", dout, 16'h0001);

    // Reset while an ADD occupies S1.
    idle(2);
    instr = mk(1, 0, 0, 0, 0, 0); valid = 1'b1;
    #1;
    chk("pre_rst_ready", ready, 1'b1);
    @(posedge clk);
    #1;
    valid = 1'b0;
    chk("s1_holds_add", busy, 1'b1);
    do_reset();
    for (int r = 0; r < 4; r++) issue(mk(0, 1, 0, r, 0, 0), 16'h0);
    idle(2);
    chk("post_rst_flags", flags, 4'h0);

    idle(5);

    // SHR1 of 1: zero result, shifted-out carry.
    issue(mk(0, 0, 0, 0, 0, 1), 16'h0001);
    issue(mk(1, 9, 0, 1, 0, 2), 16'h0);
    idle(2);
    chk("shr_flags", flags, 4'b1001);

    for (int k = 0; k < 300; k++) begin
      int mask;
      mask = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 15)) : 0;
      issue(mk($urandom_range(0, 1) == 1, int'($urandom_range(0, 15)), mask,
               int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3))), 16'($urandom));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
    end
    for (int r = 0; r < 4; r++) issue(mk(0, 1, 0, r, 0, 0), 16'h0);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
